// File: rtl/sd_digit_append.sv
// Operand-build stage for the online signed-digit multiplier: appends one radix-2
// signed digit per cycle, MSD first, into a plus/minus vector pair holding the exact prefix.
module sd_digit_append #(
    parameter int unrolling = 64
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             enable,
    input  logic                             start,
    input  logic                             digit_valid,
    input  logic [1:0]                       digit_in,
    output logic [unrolling-1:0]             vec_out_plus,
    output logic [unrolling-1:0]             vec_out_minus,
    output logic [$clog2(unrolling+1)-1:0]   digit_count,
    output logic                             full,
    output logic                             illegal_digit
);

    localparam int PW = $clog2(unrolling);
    localparam int CW = $clog2(unrolling + 1);
    localparam logic [PW-1:0] PTR_TOP = PW'(unrolling - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(unrolling);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    // Digit decode: {plus bit, minus bit, illegal flag}
    function automatic logic [2:0] decode_digit(input logic [1:0] d);
        logic [2:0] r;
        case (d)
            2'b10:   r = 3'b100;
            2'b01:   r = 3'b010;
            2'b00:   r = 3'b000;
            default: r = 3'b001;
        endcase
        return r;
    endfunction

    state_t               state_r, state_s;
    logic [PW-1:0]        ptr_r, ptr_s, wr_ptr_s;
    logic [CW-1:0]        cnt_r, cnt_s;
    logic [unrolling-1:0] plus_r, plus_s, minus_r, minus_s;
    logic                 ill_r, ill_s, full_r, full_s;
    logic                 accept_s;
    logic [2:0]           dec_s;

    // Next-state, write-position and output computation
    always_comb begin
        dec_s    = decode_digit(digit_in);
        state_s  = state_r;
        ptr_s    = ptr_r;
        wr_ptr_s = ptr_r;
        cnt_s    = cnt_r;
        plus_s   = plus_r;
        minus_s  = minus_r;
        ill_s    = ill_r;
        accept_s = 1'b0;
        if (enable) begin
            if (start) begin
                // A new operand clears everything; a same-cycle digit lands at the top position
                state_s  = ST_FILL;
                ptr_s    = PTR_TOP;
                wr_ptr_s = PTR_TOP;
                cnt_s    = {CW{1'b0}};
                plus_s   = {unrolling{1'b0}};
                minus_s  = {unrolling{1'b0}};
                ill_s    = 1'b0;
                accept_s = digit_valid;
            end else begin
                case (state_r)
                    ST_FILL: accept_s = digit_valid;
                    ST_IDLE: accept_s = 1'b0;
                    ST_FULL: accept_s = 1'b0;
                    default: state_s  = ST_IDLE;
                endcase
            end
        end else begin
            accept_s = 1'b0;
        end
        if (accept_s) begin
            plus_s[wr_ptr_s]  = dec_s[2];
            minus_s[wr_ptr_s] = dec_s[1];
            ill_s             = ill_s | dec_s[0];
            if (cnt_s != CNT_MAX) begin
                cnt_s = cnt_s + CW'(1);
            end else begin
                cnt_s = CNT_MAX;
            end
            if (wr_ptr_s == {PW{1'b0}}) begin
                state_s = ST_FULL;
            end else begin
                ptr_s = wr_ptr_s - PW'(1);
            end
        end else begin
            ptr_s = ptr_s;
        end
        full_s = (state_s == ST_FULL);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            ptr_r   <= PTR_TOP;
            cnt_r   <= {CW{1'b0}};
            plus_r  <= {unrolling{1'b0}};
            minus_r <= {unrolling{1'b0}};
            ill_r   <= 1'b0;
            full_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            cnt_r   <= cnt_s;
            plus_r  <= plus_s;
            minus_r <= minus_s;
            ill_r   <= ill_s;
            full_r  <= full_s;
        end
    end

    assign vec_out_plus  = plus_r;
    assign vec_out_minus = minus_r;
    assign digit_count   = cnt_r;
    assign full          = full_r;
    assign illegal_digit = ill_r;

endmodule

// File: tb/tb_sd_digit_append.sv
// Self-checking bench for sd_digit_append (unrolling = 8): queue-based operand model
// compared every cycle, plus hand-computed literal expectations.
module tb_sd_digit_append;

    localparam int N  = 8;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          reset_n, enable, start, digit_valid;
    logic [1:0]    digit_in;
    logic [N-1:0]  vec_out_plus, vec_out_minus;
    logic [CW-1:0] digit_count;
    logic          full, illegal_digit;

    int checks   = 0;
    int failures = 0;

    sd_digit_append #(.unrolling(N)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .start         (start),
        .digit_valid   (digit_valid),
        .digit_in      (digit_in),
        .vec_out_plus  (vec_out_plus),
        .vec_out_minus (vec_out_minus),
        .digit_count   (digit_count),
        .full          (full),
        .illegal_digit (illegal_digit)
    );

    always #5 clk = ~clk;

    // Model: the list of digits accepted since the last start, MSD first
    logic [1:0] q[$];
    bit         active = 1'b0;
    bit         m_ill  = 1'b0;
    bit         mvalid = 1'b0;

    always @(posedge clk) begin
        if (!reset_n) begin
            q.delete();
            active = 1'b0;
            m_ill  = 1'b0;
            mvalid = 1'b1;
        end else if (enable) begin
            if (start) begin
                q.delete();
                m_ill  = 1'b0;
                active = 1'b1;
                if (digit_valid) begin
                    q.push_back(digit_in);
                    if (digit_in == 2'b11) m_ill = 1'b1;
                end
            end else if (active && q.size() < N && digit_valid) begin
                q.push_back(digit_in);
                if (digit_in == 2'b11) m_ill = 1'b1;
            end
        end
    end

    function automatic logic [N-1:0] model_vec(input bit want_plus);
        logic [N-1:0] v = '0;
        for (int i = 0; i < q.size(); i++) begin
            if (want_plus && q[i] == 2'b10) v[N-1-i] = 1'b1;
            if (!want_plus && q[i] == 2'b01) v[N-1-i] = 1'b1;
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (mvalid) begin
            check("m_plus",  64'(vec_out_plus),  64'(model_vec(1'b1)));
            check("m_minus", 64'(vec_out_minus), 64'(model_vec(1'b0)));
            check("m_count", 64'(digit_count),   64'(q.size()));
            check("m_full",  64'(full),          64'(q.size() == N));
            check("m_ill",   64'(illegal_digit), 64'(m_ill));
        end
    end

    task automatic step(input logic r, input logic e, input logic s, input logic v, input logic [1:0] d);
        reset_n = r; enable = e; start = s; digit_valid = v; digit_in = d;
        @(posedge clk);
        #2;
    endtask

    task automatic lit(input string tag, input logic [N-1:0] p, input logic [N-1:0] m,
                       input int c, input logic f, input logic il);
        check({tag, "_plus"},  64'(vec_out_plus),  64'(p));
        check({tag, "_minus"}, 64'(vec_out_minus), 64'(m));
        check({tag, "_count"}, 64'(digit_count),   64'(c));
        check({tag, "_full"},  64'(full),          64'(f));
        check({tag, "_ill"},   64'(illegal_digit), 64'(il));
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b1; start = 1'b1; digit_valid = 1'b1; digit_in = 2'b10;
        #2;
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'b10);
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'b10);
        lit("reset", 8'h00, 8'h00, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 2'b10);
        lit("idle", 8'h00, 8'h00, 0, 1'b0, 1'b0);

        // start+10, 01, 00, 10
        step(1'b1, 1'b1, 1'b1, 1'b1, 2'b10);
        step(1'b1, 1'b1, 1'b0, 1'b1, 2'b01);
        step(1'b1, 1'b1, 1'b0, 1'b1, 2'b00);
        step(1'b1, 1'b1, 1'b0, 1'b1, 2'b10);
        lit("four", 8'b1001_0000, 8'b0100_0000, 4, 1'b0, 1'b0);

        // Illegal digit at position 5, then enable low with start and valid high
        step(1'b1, 1'b1, 1'b1, 1'b1, 2'b10);
        step(1'b1, 1'b1, 1'b0, 1'b1, 2'b10);
        step(1'b1, 1'b1, 1'b0, 1'b1, 2'b11);
        lit("illeg", 8'hC0, 8'h00, 3, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 2'b00);
        step(1'b1, 1'b1, 1'b0, 1'b1, 2'b00);
        step(1'b1, 1'b0, 1'b1, 1'b1, 2'b01);
        step(1'b1, 1'b0, 1'b1, 1'b1, 2'b01);
        lit("hold", 8'hC0, 8'h00, 5, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 2'b01);
        lit("resume", 8'hC0, 8'h04, 6, 1'b0, 1'b1);

        // Restart in FILL with digit 01 clears the sticky flag
        step(1'b1, 1'b1, 1'b1, 1'b1, 2'b01);
        lit("restart", 8'h00, 8'h80, 1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 2'b10);
        step(1'b1, 1'b1, 1'b0, 1'b1, 2'b10);
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'b01);
        lit("rst_start", 8'h00, 8'h00, 0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 2'b10);
        step(1'b1, 1'b1, 1'b0, 1'b1, 2'b10);
        lit("post_rst", 8'h00, 8'h00, 0, 1'b0, 1'b0);

        // Fill to full, then an ignored digit, then a back-to-back restart
        step(1'b1, 1'b1, 1'b1, 1'b1, 2'b10);
        for (int i = 0; i < N - 1; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 2'b10);
        lit("full", 8'hFF, 8'h00, 8, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 2'b01);
        lit("full_hold", 8'hFF, 8'h00, 8, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 2'b01);
        lit("full_restart", 8'h00, 8'h80, 1, 1'b0, 1'b0);

        // Start without a digit, then a gappy mixed stream checked by the model
        step(1'b1, 1'b1, 1'b1, 1'b0, 2'b10);
        lit("start_nodig", 8'h00, 8'h00, 0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++)
            step(1'b1, ($urandom_range(0, 4) != 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)));

        step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
